// File: rtl/i2s_receiver.sv
// I2S receiver: recovers left/right words from an I2S bit stream clocked by
// s_clk and queues complete stereo pairs in a small first-word-fall-through
// FIFO. Partial frames (short slots, reset mid-frame, right without a left)
// never reach the output.
module i2s_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int LVL_W = PTR_W + 1,
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  s_clk,
  input  logic                  reset,
  input  logic                  word_select,
  input  logic                  sound_bit_in,
  output logic [DATA_WIDTH-1:0] left_out,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  overflow,
  output logic                  frame_error,
  input  logic                  clear_flags
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  // Framing state
  state_t                 state;
  logic                   ws_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-2:0]  shift_reg;

  // Left-channel holding register
  logic [DATA_WIDTH-1:0]  left_hold;
  logic                   left_held;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0]  mem_left  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_right [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;

  // Decoded per-cycle events
  logic                   ws_edge;
  logic                   last_bit;
  logic                   short_slot;
  logic                   commit_left;
  logic                   commit_right;
  logic [DATA_WIDTH-1:0]  word_done;
  logic                   push_req;
  logic                   pop;
  logic                   full;
  logic                   do_push;
  logic                   overflow_set;

  // The word completes with the bit sampled in the current cycle, so the
  // committed value is the shift register with the incoming bit appended.
  assign word_done = {shift_reg, sound_bit_in};

  assign ws_edge      = (word_select != ws_q);
  assign last_bit     = (state == SHIFT) && (bit_cnt == LAST_BIT);
  // A WS edge before the final bit means the slot was too short.
  assign short_slot   = (state == SHIFT) && !last_bit && ws_edge;
  // ws_q still carries the channel of the slot that is ending, even when the
  // LSB coincides with the next WS edge.
  assign commit_left  = last_bit && !ws_q;
  assign commit_right = last_bit && ws_q;

  assign push_req     = commit_right && left_held;
  assign full         = (fifo_level == FULL_LVL);
  assign out_valid    = (fifo_level != '0);
  assign pop          = out_valid && out_ready;
  // When full, a push only lands if the head leaves in the same cycle.
  assign do_push      = push_req && (!full || pop);
  assign overflow_set = push_req && full && !pop;

  // Head of the FIFO, forced to zero while empty so reset leaves clean outputs.
  assign left_out  = out_valid ? mem_left[rd_ptr]  : '0;
  assign right_out = out_valid ? mem_right[rd_ptr] : '0;

  // Slot framing FSM: WS edge detection, bit counting and deserialisation.
  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ws_q      <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      ws_q <= word_select;
      case (state)
        IDLE: begin
          // Stay deaf until a slot boundary so a partial slot is discarded.
          if (ws_edge) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            bit_cnt <= '0;
            // Minimum-length slots: the LSB and the next boundary coincide.
            state   <= ws_edge ? SHIFT : PAD;
          end else if (ws_edge) begin
            // Short slot: drop what was collected and start the new slot.
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            shift_reg <= word_done[DATA_WIDTH-2:0];
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        PAD: begin
          // Bits beyond DATA_WIDTH are ignored until the next boundary.
          if (ws_edge) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Left holding register: pairs a completed left word with the next right word.
  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      left_hold <= '0;
      left_held <= 1'b0;
    end else if (short_slot) begin
      left_held <= 1'b0;
    end else if (commit_left) begin
      left_hold <= word_done;
      left_held <= 1'b1;
    end else if (commit_right) begin
      left_held <= 1'b0;
    end
  end

  // FIFO storage: written only; the head is read combinationally.
  always_ff @(posedge s_clk) begin
    if (do_push) begin
      mem_left[wr_ptr]  <= left_hold;
      mem_right[wr_ptr] <= word_done;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
      if (short_slot) begin
        frame_error <= 1'b1;
      end else if (clear_flags) begin
        frame_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed testbench for i2s_receiver: frame table plus hand-written
// sequences for reset, overflow, full-with-pop and mid-frame reset.
module tb_i2s_receiver;

  logic        s_clk = 1'b0;
  logic        reset = 1'b0;
  logic        word_select = 1'b0;
  logic        sound_bit_in = 1'b0;
  logic [15:0] left_out;
  logic [15:0] right_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        frame_error;
  logic        clear_flags = 1'b0;

  int errors = 0;
  int checks = 0;
  logic carry = 1'b0;
  logic [31:0] popped[$];

  i2s_receiver #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .s_clk(s_clk), .reset(reset), .word_select(word_select),
    .sound_bit_in(sound_bit_in), .left_out(left_out), .right_out(right_out),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .overflow(overflow), .frame_error(frame_error), .clear_flags(clear_flags)
  );

  always #5 s_clk = ~s_clk;

  // Record every accepted pair, sampled on the falling edge.
  always @(negedge s_clk) begin
    if (reset && out_valid && out_ready) popped.push_back({left_out, right_out});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          llen;
    int          rlen;
    bit          exp_out;
    bit          exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge s_clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One slot: MSB one cycle after the WS edge; the LSB of a minimum-length
  // slot spills into the first cycle of whatever follows.
  task automatic drive_slot(input logic w, input logic [15:0] d, input int len, input int ready_at);
    for (int k = 0; k < len; k++) begin
      word_select = w;
      if (k == 0) sound_bit_in = carry;
      else if (k <= 16) sound_bit_in = d[16-k];
      else sound_bit_in = 1'b0;
      if (ready_at >= 0) out_ready = (k == ready_at);
      tick();
    end
    carry = (len == 16) ? d[0] : 1'b0;
  endtask

  task automatic hold(input logic w, input int n);
    for (int i = 0; i < n; i++) begin
      word_select = w;
      sound_bit_in = (i == 0) ? carry : 1'b0;
      tick();
    end
    carry = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 16'h1234, 32, 32, 1'b1, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 16, 16, 1'b1, 1'b0};
    vecs[2] = '{16'h0001, 16'h8000, 20, 17, 1'b1, 1'b0};
    vecs[3] = '{16'h5A5A, 16'hC3C3, 10, 32, 1'b0, 1'b1};
    vecs[4] = '{16'h8001, 16'h7FFE, 32, 24, 1'b1, 1'b0};

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_left", 32'(left_out), 32'd0);
    check("rst_right", 32'(right_out), 32'd0);
    reset = 1'b1;
    hold(1'b0, 4);

    // Basic frame with 32-bit slots and out_valid latency
    out_ready = 1'b1;
    drive_slot(1'b1, 16'hFFFF, 32, -1);  // right with no left: dropped
    drive_slot(1'b0, 16'hA5C3, 32, -1);
    for (int k = 0; k < 32; k++) begin
      logic [15:0] d;
      d = 16'h1234;
      word_select = 1'b1;
      sound_bit_in = (k >= 1 && k <= 16) ? d[16-k] : 1'b0;
      tick();
      if (k == 15) check("lat_before_lsb", 32'(out_valid), 32'd0);
      if (k == 16) begin
        check("lat_after_lsb", 32'(out_valid), 32'd1);
        check("first_pair", {left_out, right_out}, 32'hA5C31234);
      end
    end
    check("first_count", popped.size(), 1);

    // Frame table
    for (int v = 0; v < 5; v++) begin
      popped.delete();
      drive_slot(1'b0, vecs[v].l, vecs[v].llen, -1);
      drive_slot(1'b1, vecs[v].r, vecs[v].rlen, -1);
      hold(1'b1, 4);
      check($sformatf("vec%0d_count", v), popped.size(), vecs[v].exp_out ? 1 : 0);
      if (vecs[v].exp_out && popped.size() > 0)
        check($sformatf("vec%0d_pair", v), popped[0], {vecs[v].l, vecs[v].r});
      check($sformatf("vec%0d_ferr", v), 32'(frame_error), 32'(vecs[v].exp_ferr));
      if (frame_error) begin
        pulse_clear();
        check($sformatf("vec%0d_ferr_clear", v), 32'(frame_error), 32'd0);
      end
    end

    // Overflow: six frames with consumer stalled
    popped.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_slot(1'b0, 16'h1000 + 16'(i), 32, -1);
      drive_slot(1'b1, 16'h2000 + 16'(i), 32, -1);
    end
    hold(1'b1, 4);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_nopop", popped.size(), 0);
    out_ready = 1'b1;
    hold(1'b1, 8);
    out_ready = 1'b0;
    check("ovf_drain_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      check($sformatf("ovf_drain%0d", i), popped[i], {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
    check("ovf_drain_level", 32'(fifo_level), 32'd0);

    // Full FIFO, push and pop in the same cycle
    pulse_clear();
    check("clear_ovf", 32'(overflow), 32'd0);
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      drive_slot(1'b0, 16'h3000 + 16'(i), 32, -1);
      drive_slot(1'b1, 16'h4000 + 16'(i), 32, -1);
    end
    check("full_level", 32'(fifo_level), 32'd4);
    drive_slot(1'b0, 16'h3004, 32, -1);
    drive_slot(1'b1, 16'h4004, 32, 16);
    check("simul_level", 32'(fifo_level), 32'd4);
    check("simul_ovf", 32'(overflow), 32'd0);
    check("simul_pop_count", popped.size(), 1);
    out_ready = 1'b1;
    hold(1'b1, 8);
    check("simul_drain_count", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      check($sformatf("simul_drain%0d", i), popped[i], {16'h3000 + 16'(i), 16'h4000 + 16'(i)});

    // Reset pulse during the right slot
    popped.delete();
    drive_slot(1'b0, 16'h1111, 32, -1);
    for (int k = 0; k < 32; k++) begin
      logic [15:0] d;
      d = 16'h9999;
      word_select = 1'b1;
      sound_bit_in = (k >= 1 && k <= 16) ? d[16-k] : 1'b0;
      if (k == 8) reset = 1'b0;
      if (k == 10) reset = 1'b1;
      if (k == 9) begin
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
      end
      tick();
    end
    carry = 1'b0;
    check("midrst_nopair", popped.size(), 0);
    drive_slot(1'b0, 16'h2222, 32, -1);
    drive_slot(1'b1, 16'h3333, 32, -1);
    hold(1'b1, 4);
    check("midrst_count", popped.size(), 1);
    if (popped.size() > 0) check("midrst_pair", popped[0], 32'h22223333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
